// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Entry widths are fixed here; fetch_unit's width parameters must match them.
package fetch_pkg;

    localparam int FETCH_ADDR_W    = 32;
    localparam int FETCH_DATA_W    = 32;
    localparam int IMEM_WORD_BYTES = 4;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between fetch_unit and its environment: redirect input,
// imem request/response channels and the decode-side instruction handshake.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int AddrWidth = FETCH_ADDR_W,
    parameter int DataWidth = FETCH_DATA_W
);

    logic                 redirect_valid;
    logic [AddrWidth-1:0] redirect_addr;

    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [AddrWidth-1:0] imem_req_addr;

    logic                 imem_rsp_valid;
    logic [DataWidth-1:0] imem_rsp_data;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [DataWidth-1:0] instr;
    logic [AddrWidth-1:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_addr,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_addr,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small registered FIFO of fetched {instr, pc} entries with synchronous flush.
// Storage is not reset; only pointers and count are.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int BufDepth = 2,
    localparam int CntW = $clog2(BufDepth) + 1,
    localparam int PtrW = $clog2(BufDepth)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  fetch_entry_t    push_data,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    head,
    output logic [CntW-1:0] count
);

    fetch_entry_t    mem [BufDepth];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited imem requests,
// buffers in-order responses and squashes stale responses after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   AddrWidth = FETCH_ADDR_W,
    parameter int                   DataWidth = FETCH_DATA_W,
    parameter logic [AddrWidth-1:0] ResetAddr = '0,
    parameter int                   BufDepth  = 2
) (
    input logic      clk,
    input logic      reset,
    fetch_if.master  bus
);

    localparam int CntW = $clog2(BufDepth) + 1;
    localparam int SumW = CntW + 2;
    localparam logic [AddrWidth-1:0] WordStep = AddrWidth'(IMEM_WORD_BYTES);

    logic [AddrWidth-1:0] pc;
    logic [AddrWidth-1:0] rsp_pc;
    logic [AddrWidth-1:0] redirect_pc;
    logic [CntW-1:0]      in_flight;
    logic [CntW-1:0]      drop;
    logic [CntW-1:0]      fifo_count;
    logic [SumW-1:0]      outstanding;
    logic                 credit;
    logic                 req_hs;
    logic                 rsp_drop;
    logic                 rsp_keep;
    logic                 pop;
    logic                 push;
    fetch_entry_t         push_entry;
    fetch_entry_t         head;

    // Every issued-but-unconsumed fetch holds a FIFO slot, so responses never stall.
    assign outstanding = SumW'(in_flight) + SumW'(drop) + SumW'(fifo_count);
    assign credit      = outstanding < SumW'(BufDepth);

    assign bus.imem_req_valid = credit && !reset;
    assign bus.imem_req_addr  = pc;

    assign req_hs      = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_drop    = bus.imem_rsp_valid && (drop != '0);
    assign rsp_keep    = bus.imem_rsp_valid && (drop == '0);
    assign pop         = bus.instr_valid && bus.instr_ready;
    assign push        = rsp_keep && !bus.redirect_valid;
    assign redirect_pc = {bus.redirect_addr[AddrWidth-1:2], 2'b00};

    assign push_entry.instr = bus.imem_rsp_data;
    assign push_entry.pc    = rsp_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= ResetAddr;
            rsp_pc    <= ResetAddr;
            in_flight <= '0;
            drop      <= '0;
        end else if (bus.redirect_valid) begin
            // Everything still owed by imem, including a request accepted now, becomes stale.
            pc        <= redirect_pc;
            rsp_pc    <= redirect_pc;
            drop      <= drop + in_flight + CntW'(req_hs) - CntW'(bus.imem_rsp_valid);
            in_flight <= '0;
        end else begin
            if (req_hs)   pc     <= pc + WordStep;
            if (rsp_keep) rsp_pc <= rsp_pc + WordStep;
            if (rsp_drop) drop   <= drop - CntW'(1);
            in_flight <= in_flight + CntW'(req_hs) - CntW'(rsp_keep);
        end
    end

    fetch_fifo #(
        .BufDepth (BufDepth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .count     (fifo_count)
    );

    // Head storage is unreset, so the outputs are forced to zero when nothing is buffered.
    assign bus.instr_valid = (fifo_count != '0);
    assign bus.instr       = bus.instr_valid ? head.instr : '0;
    assign bus.instr_pc    = bus.instr_valid ? head.pc    : '0;

endmodule
